reg_writeback_ctrl: RTL and testbench
=====================================

Name: reg_writeback_ctrl

Overview:
- Write-side initiator for the 32-entry MIPS register file (single write port, two read ports).
- Accepts completed results from the execute/memory stages over a valid/ready handshake and buffers them in an in-order FIFO.
- Retires one result per cycle onto the register-file write port (reg_write / wb_addr / wb_data).
- Provides two forwarding lookups so the decode stage can read pending values that have not yet been written.

Parameters:
DATA_W, 32, result/register data width
ADDR_W, 5, register address width (MIPS numbering; $zero = 0)
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
res_valid  in  1  producer has a result this cycle
res_ready  out  1  buffer can accept a result
res_dest  in  ADDR_W  destination register of the result
res_data  in  DATA_W  result value
wr_stall  in  1  register-file write port unavailable; hold head entry
reg_write  out  1  write strobe to register file, one cycle per retired entry
wb_addr  out  ADDR_W  write address to register file
wb_data  out  DATA_W  write data to register file
fwd_addr_a  in  ADDR_W  forwarding lookup address, port A
fwd_hit_a  out  1  pending value exists for fwd_addr_a
fwd_data_a  out  DATA_W  youngest pending value for fwd_addr_a (0 if no hit)
fwd_addr_b  in  ADDR_W  forwarding lookup address, port B
fwd_hit_b  out  1  same as A, port B
fwd_data_b  out  DATA_W  same as A, port B
count  out  $clog2(DEPTH)+1  number of FIFO entries held
empty  out  1  count == 0 and reg_write == 0

Behaviour:
- Reset (rst_n low, async): rd/wr pointers, count, reg_write, wb_addr and wb_data go to 0. res_ready = 0 while rst_n is low; empty = 1; fwd_hit_* = 0.
- Storage: circular FIFO, DEPTH entries of {dest, data}. Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full = MSBs differ and low bits are equal.
- res_ready = rst_n && !full. It is combinational from the registered count, and deliberately does not depend on a same-cycle pop.
- Push: occurs on a clock edge when res_valid && res_ready.
  - res_dest == 0: handshake completes, data is discarded, nothing is enqueued.
  - Otherwise: write the entry and increment the write pointer.
- Pop: occurs on a clock edge when count != 0 && !wr_stall. The head entry is loaded into wb_addr/wb_data, reg_write <= 1, and the read pointer increments. Otherwise reg_write <= 0 and wb_addr/wb_data hold their last values.
- reg_write is a single-cycle pulse per entry. Back-to-back pops give a continuous high with changing addr/data.
- Latency: a result accepted at edge k (FIFO empty, no stall) is popped at edge k+1, so reg_write is high between edge k+1 and edge k+2. The minimum is 1 cycle from acceptance to write strobe.
- Simultaneous push and pop in the same edge: count is unchanged, and both pointers advance.
- Retirement order is strictly FIFO. Multiple pending writes to the same register retire oldest first.
- wr_stall during an active strobe: the current strobe still completes (reg_write drops next cycle). The stall only blocks the next pop.
- Forwarding (combinational, per port):
  - Search all valid FIFO entries from youngest to oldest, then the wb output register while reg_write = 1.
  - The first match on dest == fwd_addr wins, giving hit = 1 and data = that entry's data.
  - fwd_addr == 0 never hits.
  - Results presented this cycle but not yet accepted are not visible.
- Mid-operation reset discards all pending entries and does not complete a partial write.
- No overflow is possible because push is blocked when full. Pop on empty is a no-op.

Test Plan:
- Reset then single push dest=9, data=0x0000_00AA at edge 1 -> reg_write=1, wb_addr=9, wb_data=0xAA in cycle after edge 2 only; empty=1 after edge 3.
- wr_stall=1, push dest 8,9,10,11 with data 1,2,3,4 -> count=4, res_ready=0, fifth push held. Release stall -> four consecutive strobes 8/1, 9/2, 10/3, 11/4; res_ready=1 after the first pop.
- Push dest=0, data=0xFFFF_FFFF -> handshake completes, count stays 0, no reg_write.
- Stall, push 12/0x10 then 12/0x20; fwd_addr_a=12, fwd_addr_b=13 -> fwd_hit_a=1, fwd_data_a=0x20, fwd_hit_b=0, fwd_data_b=0. fwd_addr_a=0 -> no hit.
- Full FIFO, no stall, res_valid held high -> push is blocked on the edge where the pop happens, then accepted the next cycle; the order of all entries is preserved and the pointers wrap correctly over 3*DEPTH pushes.
- Assert rst_n low asynchronously mid-drain with count=3 -> reg_write, count and wb_* go to 0 immediately, res_ready=0; after release no stale write occurs.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// Write-back buffer for the MIPS register file: queues completed results in order,
// retires one per cycle onto the single write port and forwards pending values to decode.
module reg_writeback_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     res_valid,
    output logic                     res_ready,
    input  logic [ADDR_W-1:0]        res_dest,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     wr_stall,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        fwd_addr_a,
    output logic                     fwd_hit_a,
    output logic [DATA_W-1:0]        fwd_data_a,
    input  logic [ADDR_W-1:0]        fwd_addr_b,
    output logic                     fwd_hit_b,
    output logic [DATA_W-1:0]        fwd_data_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [ADDR_W-1:0] mem_dest [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              accept;
    logic              push;
    logic              pop;

    // The extra pointer bit distinguishes a full ring from an empty one.
    assign full      = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign res_ready = rst_n && !full;
    assign accept    = res_valid && res_ready;
    // Writes to $zero complete the handshake but are never queued.
    assign push      = accept && (res_dest != '0);
    assign pop       = (count != '0) && !wr_stall;
    assign empty     = (count == '0) && !reg_write;

    // NOTE: storage is deliberately not reset; count and the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr[IW-1:0]] <= res_dest;
            mem_data[wr_ptr[IW-1:0]] <= res_data;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            reg_write <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                wb_addr   <= mem_dest[rd_ptr[IW-1:0]];
                wb_data   <= mem_data[rd_ptr[IW-1:0]];
                reg_write <= 1'b1;
            end else begin
                reg_write <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lowest priority is the strobe in flight; queue entries scanned oldest to
    // youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [IW-1:0] idx;
        // NOTE: defaults first so no path through this block leaves an output unassigned (no latches).
        idx        = '0;
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        if (reg_write && (wb_addr == fwd_addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = wb_data;
        end
        if (reg_write && (wb_addr == fwd_addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = wb_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr[IW-1:0] + IW'(i);
            if (PW'(i) < count) begin
                if (mem_dest[idx] == fwd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = mem_data[idx];
                end
                if (mem_dest[idx] == fwd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = mem_data[idx];
                end
            end
        end
        if (fwd_addr_a == '0) begin
            fwd_hit_a  = 1'b0;
            fwd_data_a = '0;
        end
        if (fwd_addr_b == '0) begin
            fwd_hit_b  = 1'b0;
            fwd_data_b = '0;
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_reg_writeback_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   res_valid;
    logic                   res_ready;
    logic [ADDR_W-1:0]      res_dest;
    logic [DATA_W-1:0]      res_data;
    logic                   wr_stall;
    logic                   reg_write;
    logic [ADDR_W-1:0]      wb_addr;
    logic [DATA_W-1:0]      wb_data;
    logic [ADDR_W-1:0]      fwd_addr_a;
    logic                   fwd_hit_a;
    logic [DATA_W-1:0]      fwd_data_a;
    logic [ADDR_W-1:0]      fwd_addr_b;
    logic                   fwd_hit_b;
    logic [DATA_W-1:0]      fwd_data_b;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;

    reg_writeback_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_dest(res_dest), .res_data(res_data),
        .wr_stall(wr_stall), .reg_write(reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_addr_a(fwd_addr_a), .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_addr_b(fwd_addr_b), .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: pending results in arrival order plus the write-port register.
    entry_t            q[$];
    logic              m_rw;
    logic [ADDR_W-1:0] m_wb_addr;
    logic [DATA_W-1:0] m_wb_data;
    logic              last_accept;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_rw      = 1'b0;
        m_wb_addr = '0;
        m_wb_data = '0;
    endfunction

    function automatic logic model_ready();
        return rst_n && (q.size() < DEPTH);
    endfunction

    // Youngest pending value wins; the in-flight strobe is the oldest candidate.
    function automatic void model_fwd(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a == '0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].dest == a) begin
                hit = 1'b1;
                d   = q[i].data;
                return;
            end
        end
        if (m_rw && m_wb_addr == a) begin
            hit = 1'b1;
            d   = m_wb_data;
        end
    endfunction

    task automatic check_outputs();
        logic              h;
        logic [DATA_W-1:0] d;
        check("res_ready", 32'(res_ready), 32'(model_ready()));
        check("reg_write", 32'(reg_write), 32'(m_rw));
        check("wb_addr",   32'(wb_addr),   32'(m_wb_addr));
        check("wb_data",   wb_data,        m_wb_data);
        check("count",     32'(count),     32'(q.size()));
        check("empty",     32'(empty),     32'(q.size() == 0 && !m_rw));
        model_fwd(fwd_addr_a, h, d);
        check("fwd_hit_a",  32'(fwd_hit_a), 32'(h));
        check("fwd_data_a", fwd_data_a,     d);
        model_fwd(fwd_addr_b, h, d);
        check("fwd_hit_b",  32'(fwd_hit_b), 32'(h));
        check("fwd_data_b", fwd_data_b,     d);
    endtask

    // Checks at the falling edge, then advances the model across the next rising edge.
    task automatic cycle();
        logic   do_push;
        logic   do_pop;
        entry_t e;
        @(negedge clk);
        check_outputs();
        last_accept = res_valid && model_ready();
        do_push     = last_accept && (res_dest != '0);
        do_pop      = rst_n && (q.size() != 0) && !wr_stall;
        e.dest      = res_dest;
        e.data      = res_data;
        @(posedge clk);
        if (rst_n) begin
            if (do_pop) begin
                m_wb_addr = q[0].dest;
                m_wb_data = q[0].data;
                m_rw      = 1'b1;
                void'(q.pop_front());
            end else begin
                m_rw = 1'b0;
            end
            if (do_push) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] dst, input logic [DATA_W-1:0] dat);
        res_valid = v;
        res_dest  = dst;
        res_data  = dat;
    endtask

    initial begin
        int pushed;
        int guard;

        rst_n = 1'b0; wr_stall = 1'b0; fwd_addr_a = '0; fwd_addr_b = '0;
        last_accept = 1'b0;
        drive(1'b0, '0, '0);
        model_reset();
        #3;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single result: strobe appears one edge after acceptance, then buffer empties.
        fwd_addr_a = 5'd9;
        drive(1'b1, 5'd9, 32'h0000_00AA);
        cycle();
        drive(1'b0, '0, '0);
        repeat (4) cycle();

        // Fill under stall, fifth result held, then drain back to back.
        wr_stall = 1'b1;
        fwd_addr_a = 5'd10; fwd_addr_b = 5'd8;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(8 + i), DATA_W'(i + 1));
            cycle();
        end
        drive(1'b1, 5'd20, 32'h55);
        repeat (2) cycle();
        drive(1'b0, '0, '0);
        wr_stall = 1'b0;
        repeat (6) cycle();

        // Writes to $zero are acknowledged and dropped.
        drive(1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        drive(1'b0, '0, '0);
        repeat (2) cycle();

        // Forwarding: youngest of two pending writes to r12; $zero never hits.
        wr_stall = 1'b1;
        fwd_addr_a = 5'd12; fwd_addr_b = 5'd13;
        drive(1'b1, 5'd12, 32'h10); cycle();
        drive(1'b1, 5'd12, 32'h20); cycle();
        drive(1'b0, '0, '0);        cycle();
        fwd_addr_a = 5'd0;          cycle();
        fwd_addr_a = 5'd12;
        wr_stall = 1'b0;
        repeat (4) cycle();

        // Full buffer with res_valid held: ordering and pointer wrap over 3*DEPTH results.
        wr_stall = 1'b1;
        pushed = 0;
        guard  = 0;
        drive(1'b1, 5'd1, 32'h100);
        while (pushed < 3 * DEPTH && guard < 100) begin
            if (guard == 6) wr_stall = 1'b0;
            fwd_addr_a = ADDR_W'(1 + (pushed % 31));
            cycle();
            guard++;
            if (last_accept) begin
                pushed++;
                drive(1'b1, ADDR_W'(1 + (pushed % 31)), DATA_W'(32'h100 + pushed));
            end
        end
        check("wrap_bound", 32'(pushed), 32'(3 * DEPTH));
        drive(1'b0, '0, '0);
        repeat (6) cycle();

        // Asynchronous reset mid-drain with three entries pending.
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ADDR_W'(16 + i), DATA_W'(32'hA0 + i));
            cycle();
        end
        drive(1'b0, '0, '0);
        wr_stall = 1'b0;
        cycle();
        @(negedge clk);
        check_outputs();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        rst_n = 1'b1;
        repeat (4) cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 7)), $urandom);
            wr_stall   = ($urandom_range(0, 3) == 0);
            fwd_addr_a = ADDR_W'($urandom_range(0, 7));
            fwd_addr_b = ADDR_W'($urandom_range(0, 7));
            cycle();
        end
        drive(1'b0, '0, '0);
        wr_stall = 1'b0;
        repeat (8) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
